// File: rtl/decode_ctrl_if.sv
// Handshake and decoded-control bundle between IF and ID/EX for the decode stage.
// master = upstream/downstream environment view, slave = decode stage view.
interface decode_ctrl_if #(
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [PC_W-1:0] out_pc;
  logic            memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump;
  logic            jal, jr, bal, memen, hilowrite, cp0write;
  logic [3:0]      aluop;
  logic            exc_syscall, exc_break, exc_eret, exc_ri;
  logic            in_delay_slot;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc,
    input  memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump,
    input  jal, jr, bal, memen, hilowrite, cp0write, aluop,
    input  exc_syscall, exc_break, exc_eret, exc_ri, in_delay_slot
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc,
    output memtoreg, memwrite, branch, alusrc, regdst, regwrite, jump,
    output jal, jr, bal, memen, hilowrite, cp0write, aluop,
    output exc_syscall, exc_break, exc_eret, exc_ri, in_delay_slot
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// Registered MIPS main decoder: decodes on accept, buffers results in a 2-entry skid FIFO.
// Latency 1 cycle into an empty FIFO; in_ready drops when both entries are full or on flush/reset.
module decode_ctrl_stage #(
  parameter int PC_W          = 32,
  parameter int ENABLE_MULDIV = 1,
  parameter int ENABLE_CP0    = 1
) (
  input logic          clk,
  input logic          rst,
  decode_ctrl_if.slave bus
);

  typedef struct packed {
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic       regwrite;
    logic       jump;
    logic       jal;
    logic       jr;
    logic       bal;
    logic       memen;
    logic       hilowrite;
    logic       cp0write;
    logic [3:0] aluop;
    logic       exc_syscall;
    logic       exc_break;
    logic       exc_eret;
    logic       exc_ri;
  } dec_t;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    dec_t            dec;
    logic            ds;
  } entry_t;

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  dec_t       dec;

  assign op = bus.in_inst[31:26];
  assign rs = bus.in_inst[25:21];
  assign rt = bus.in_inst[20:16];
  assign fn = bus.in_inst[5:0];

  always_comb begin
    dec = '0;
    case (op)
      6'b000000: begin
        if (bus.in_inst != 32'd0) begin
          case (fn)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2a, 6'h2b: begin
              dec.regdst   = 1'b1;
              dec.regwrite = 1'b1;
              dec.aluop    = 4'b1000;
            end
            6'h08: begin
              dec.jump  = 1'b1;
              dec.jr    = 1'b1;
              dec.aluop = 4'b0100;
            end
            6'h09: begin
              dec.regdst   = 1'b1;
              dec.regwrite = 1'b1;
              dec.jr       = 1'b1;
              dec.aluop    = 4'b0100;
            end
            6'h0c: dec.exc_syscall = 1'b1;
            6'h0d: dec.exc_break   = 1'b1;
            // mfhi/mflo write the GPR file, the rest of the HI/LO group writes HI/LO
            6'h10, 6'h12: begin
              if (ENABLE_MULDIV != 0) begin
                dec.regdst   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = 4'b1000;
              end else begin
                dec.exc_ri = 1'b1;
              end
            end
            6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: begin
              if (ENABLE_MULDIV != 0) begin
                dec.hilowrite = 1'b1;
                dec.aluop     = 4'b1000;
              end else begin
                dec.exc_ri = 1'b1;
              end
            end
            default: dec.exc_ri = 1'b1;
          endcase
        end
      end
      6'b000001: begin
        case (rt)
          5'b00000, 5'b00001: dec.branch = 1'b1;
          5'b10000, 5'b10001: begin
            dec.branch   = 1'b1;
            dec.regwrite = 1'b1;
            dec.bal      = 1'b1;
          end
          default: dec.exc_ri = 1'b1;
        endcase
      end
      6'b000010: begin
        dec.jump  = 1'b1;
        dec.aluop = 4'b0100;
      end
      6'b000011: begin
        dec.regwrite = 1'b1;
        dec.jal      = 1'b1;
        dec.aluop    = 4'b0100;
      end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: dec.branch = 1'b1;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        case (op[2:0])
          3'b000:  dec.aluop = 4'b0100;
          3'b001:  dec.aluop = 4'b0101;
          3'b010:  dec.aluop = 4'b0110;
          3'b011:  dec.aluop = 4'b0111;
          3'b100:  dec.aluop = 4'b0000;
          3'b101:  dec.aluop = 4'b0010;
          3'b110:  dec.aluop = 4'b0001;
          default: dec.aluop = 4'b0011;
        endcase
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.memen    = 1'b1;
        dec.aluop    = 4'b0100;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memen    = 1'b1;
        dec.aluop    = 4'b0100;
      end
      6'b010000: begin
        if (ENABLE_CP0 == 0) begin
          dec.exc_ri = 1'b1;
        end else if (rs == 5'b00100) begin
          dec.cp0write = 1'b1;
          dec.aluop    = 4'b1010;
        end else if (rs == 5'b00000) begin
          dec.regwrite = 1'b1;
          dec.aluop    = 4'b1001;
        end else if (rs == 5'b10000 && fn == 6'b011000) begin
          dec.exc_eret = 1'b1;
        end else begin
          dec.exc_ri = 1'b1;
        end
      end
      default: dec.exc_ri = 1'b1;
    endcase
  end

  entry_t     mem [2];
  entry_t     head;
  entry_t     wr_entry;
  logic [1:0] count;
  logic       rd_ptr;
  logic       wr_ptr;
  logic       ds_pending;
  logic       push;
  logic       pop;
  logic       is_cf;
  dec_t       head_dec;

  assign bus.in_ready  = !rst && !bus.flush && (count < 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign is_cf         = dec.branch | dec.jump | dec.jr | dec.jal | dec.bal;

  always_comb begin
    wr_entry.inst = bus.in_inst;
    wr_entry.pc   = bus.in_pc;
    wr_entry.dec  = dec;
    wr_entry.ds   = ds_pending;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      ds_pending <= 1'b0;
      mem[0]     <= '0;
      mem[1]     <= '0;
    end else if (bus.flush) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      ds_pending <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
        ds_pending  <= is_cf;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Every head-derived output reads as zero while the FIFO is empty.
  assign head     = bus.out_valid ? mem[rd_ptr] : '0;
  assign head_dec = head.dec;

  assign bus.out_inst      = head.inst;
  assign bus.out_pc        = head.pc;
  assign bus.in_delay_slot = head.ds;
  assign bus.memtoreg      = head_dec.memtoreg;
  assign bus.memwrite      = head_dec.memwrite;
  assign bus.branch        = head_dec.branch;
  assign bus.alusrc        = head_dec.alusrc;
  assign bus.regdst        = head_dec.regdst;
  assign bus.regwrite      = head_dec.regwrite;
  assign bus.jump          = head_dec.jump;
  assign bus.jal           = head_dec.jal;
  assign bus.jr            = head_dec.jr;
  assign bus.bal           = head_dec.bal;
  assign bus.memen         = head_dec.memen;
  assign bus.hilowrite     = head_dec.hilowrite;
  assign bus.cp0write      = head_dec.cp0write;
  assign bus.aluop         = head_dec.aluop;
  assign bus.exc_syscall   = head_dec.exc_syscall;
  assign bus.exc_break     = head_dec.exc_break;
  assign bus.exc_eret      = head_dec.exc_eret;
  assign bus.exc_ri        = head_dec.exc_ri;

endmodule
